node_port: RTL and testbench

//  Local-port network interface between a processing element (PE) and port

---
 rtl/node_port_if.sv | 47 ++++
 rtl/node_port.sv | 195 +++++++++++++++++++
 tb/tb_node_port.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_port_if.sv
// Bundle of PE-side valid/ready signals and switch-side 4-phase r/w signals
// for one local network port, plus FSM state visibility.
interface node_port_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;

  // PE side
  logic                 pe_valid;
  logic [ADDR_SIZE-1:0] pe_dest;
  logic [DATA_SIZE-1:0] pe_data;
  logic                 pe_ready;
  logic                 rx_valid;
  logic                 rx_src_ok;
  logic [DATA_SIZE-1:0] rx_data;
  logic                 rx_ready;

  // Switch side
  logic                 sw_in_r;
  logic                 sw_in_w;
  logic [BUS_SIZE-1:0]  sw_data_o;
  logic                 sw_out_r;
  logic                 sw_out_w;
  logic [BUS_SIZE-1:0]  sw_data_i;

  // Status
  logic [15:0]          tx_cnt;
  logic [15:0]          rx_cnt;
  logic [7:0]           err_cnt;
  logic [1:0]           tx_state;
  logic                 rx_state;

  // The port itself
  modport slave (
    input  pe_valid, pe_dest, pe_data, rx_ready, sw_in_w, sw_out_r, sw_data_i,
    output pe_ready, rx_valid, rx_src_ok, rx_data, sw_in_r, sw_data_o, sw_out_w,
    output tx_cnt, rx_cnt, err_cnt, tx_state, rx_state
  );

  // The PE and switch driving the port
  modport master (
    output pe_valid, pe_dest, pe_data, rx_ready, sw_in_w, sw_out_r, sw_data_i,
    input  pe_ready, rx_valid, rx_src_ok, rx_data, sw_in_r, sw_data_o, sw_out_w,
    input  tx_cnt, rx_cnt, err_cnt, tx_state, rx_state
  );
endinterface

// File: rtl/node_port.sv
// Local-port network interface: TX FIFO + 4-phase injector towards the switch,
// 4-phase ejection receiver + RX FIFO towards the PE.
//
// Handshakes: pe_* and rx_* are valid/ready (a beat moves when both are high at
// a clk edge); sw_in_* and sw_out_* are 4-phase: r rises with data stable, w
// rises, r falls, w falls; the receiver captures on the edge it first sees r=1.
module node_port #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int ADDR      = 0,
  parameter int FIFO_LOG2 = 2
) (
  input  logic         clk,
  input  logic         a_rst,
  node_port_if.slave   bus
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int ENTRY    = DATA_SIZE + ADDR_SIZE;
  localparam int DEPTH    = 1 << FIFO_LOG2;
  localparam logic [ADDR_SIZE-1:0] MY_ADDR = ADDR[ADDR_SIZE-1:0];
  localparam logic [FIFO_LOG2:0]   PTR_ONE = {{FIFO_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_REL = 2'd2} tx_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [ENTRY-1:0]   tx_mem [DEPTH];
  logic [FIFO_LOG2:0] tx_wr_ptr, tx_rd_ptr;
  logic               tx_empty, tx_full, tx_push, tx_pop, tx_load;
  logic               pe_ready;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[FIFO_LOG2] != tx_rd_ptr[FIFO_LOG2]) &&
                    (tx_wr_ptr[FIFO_LOG2-1:0] == tx_rd_ptr[FIFO_LOG2-1:0]);
  // A full FIFO still takes a word in the cycle its head is popped; the head
  // already sits in sw_data_o, so its slot may be overwritten at that edge.
  assign pe_ready = !tx_full || tx_pop;
  assign tx_push  = bus.pe_valid && pe_ready;
  assign bus.pe_ready = pe_ready;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[FIFO_LOG2-1:0]] <= {bus.pe_dest, bus.pe_data};
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e          tx_state_q, tx_state_d;
  logic               sw_in_r_q, sw_in_r_d;
  logic [BUS_SIZE-1:0] sw_data_o_q;
  logic [15:0]        tx_cnt_q;

  always_ff @(posedge clk) begin
    if (!a_rst) tx_state_q <= T_IDLE;
    else        tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_IDLE:  if (!tx_empty)   tx_state_d = T_REQ;
      T_REQ:   if (bus.sw_in_w) tx_state_d = T_REL;
      T_REL:   if (!bus.sw_in_w) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    tx_load   = 1'b0;
    tx_pop    = 1'b0;
    sw_in_r_d = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        tx_load   = !tx_empty;
        sw_in_r_d = !tx_empty;
      end
      T_REQ: begin
        tx_pop    = bus.sw_in_w;
        sw_in_r_d = !bus.sw_in_w;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      sw_in_r_q   <= 1'b0;
      sw_data_o_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      sw_in_r_q <= sw_in_r_d;
      if (tx_load) sw_data_o_q <= {1'b1, tx_mem[tx_rd_ptr[FIFO_LOG2-1:0]]};
      if (tx_pop)  tx_cnt_q    <= tx_cnt_q + 16'd1;
    end
  end

  assign bus.sw_in_r   = sw_in_r_q;
  assign bus.sw_data_o = sw_data_o_q;
  assign bus.tx_cnt    = tx_cnt_q;
  assign bus.tx_state  = tx_state_q;

  // ---------------- RX FIFO ----------------
  logic [ENTRY-1:0]   rx_mem [DEPTH];
  logic [FIFO_LOG2:0] rx_wr_ptr, rx_rd_ptr;
  logic               rx_empty, rx_full, rx_push, rx_pop;
  logic [ENTRY-1:0]   rx_head;
  logic               rx_flit_bad;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[FIFO_LOG2] != rx_rd_ptr[FIFO_LOG2]) &&
                    (rx_wr_ptr[FIFO_LOG2-1:0] == rx_rd_ptr[FIFO_LOG2-1:0]);
  assign rx_pop   = bus.rx_ready && !rx_empty;
  assign rx_head  = rx_mem[rx_rd_ptr[FIFO_LOG2-1:0]];

  assign bus.rx_valid  = !rx_empty;
  assign bus.rx_data   = rx_head[DATA_SIZE-1:0];
  assign bus.rx_src_ok = (rx_head[ENTRY-1 -: ADDR_SIZE] == MY_ADDR);

  assign rx_flit_bad = !bus.sw_data_i[BUS_SIZE-1] ||
                       (bus.sw_data_i[BUS_SIZE-2 -: ADDR_SIZE] != MY_ADDR);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[FIFO_LOG2-1:0]] <= bus.sw_data_i[ENTRY-1:0];
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e   rx_state_q, rx_state_d;
  logic        sw_out_w_q, sw_out_w_d;
  logic [15:0] rx_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (!a_rst) rx_state_q <= R_IDLE;
    else        rx_state_q <= rx_state_d;
  end

  // A full RX FIFO simply withholds w; the switch keeps r high and waits.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_IDLE:  if (bus.sw_out_r && !rx_full) rx_state_d = R_ACK;
      R_ACK:   if (!bus.sw_out_r)            rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_push    = 1'b0;
    sw_out_w_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_push    = bus.sw_out_r && !rx_full;
        sw_out_w_d = bus.sw_out_r && !rx_full;
      end
      R_ACK:   sw_out_w_d = bus.sw_out_r;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      sw_out_w_q <= 1'b0;
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      sw_out_w_q <= sw_out_w_d;
      if (rx_push) rx_cnt_q <= rx_cnt_q + 16'd1;
      if (rx_push && rx_flit_bad && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.sw_out_w = sw_out_w_q;
  assign bus.rx_cnt   = rx_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.rx_state = rx_state_q;

endmodule

// File: tb/tb_node_port.sv
// Scoreboard bench for node_port: a switch-sink process and a PE-side RX
// monitor pop expected flits queued by the stimulus tasks.
module tb_node_port;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = DW + AW + 1;
  localparam int MY = 0;

  logic clk = 1'b0;
  logic a_rst = 1'b0;
  always #5 clk = ~clk;

  node_port_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus();
  node_port #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .ADDR(MY), .FIFO_LOG2(2)) dut (
    .clk(clk), .a_rst(a_rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [BW-1:0] tx_exp_q[$];
  logic [DW:0]   rx_exp_q[$];   // {src_ok, data}
  int tx_seen, rx_model, err_model, rx_acked;
  bit sink_en = 1'b0;
  int ack_delay = 0;            // negative selects a random delay per flit
  int rx_mode = 0;              // 0 hold, 1 always pop, 2 random
  bit pop_one = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- switch sink on the injection side ----------------
  initial begin
    int d;
    bus.sw_in_w = 1'b0;
    forever begin
      @(negedge clk);
      if (!a_rst || !sink_en) begin
        bus.sw_in_w = 1'b0;
      end else if (bus.sw_in_r && !bus.sw_in_w) begin
        if (tx_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got flit 0x%0h, expected none", bus.sw_data_o);
        end else begin
          check("tx_flit", bus.sw_data_o, tx_exp_q.pop_front());
        end
        d = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
        repeat (d) begin
          @(negedge clk);
          check("tx_req_hold", bus.sw_in_r, 1);
        end
        bus.sw_in_w = 1'b1;
        @(negedge clk);
        check("tx_req_release", bus.sw_in_r, 0);
        tx_seen++;
        bus.sw_in_w = 1'b0;
        @(negedge clk);
        check("tx_req_gap", bus.sw_in_r, 0);
      end
    end
  end

  // ---------------- PE-side RX monitor ----------------
  initial begin
    logic [DW:0] e;
    bus.rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_one) begin
        bus.rx_ready = 1'b1;
        pop_one = 1'b0;
      end else begin
        case (rx_mode)
          0:       bus.rx_ready = 1'b0;
          1:       bus.rx_ready = 1'b1;
          default: bus.rx_ready = 1'($urandom_range(0, 1));
        endcase
      end
      #1;
      if (a_rst && bus.rx_ready && bus.rx_valid) begin
        if (rx_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got data 0x%0h, expected none", bus.rx_data);
        end else begin
          e = rx_exp_q.pop_front();
          check("rx_data", bus.rx_data, e[DW-1:0]);
          check("rx_src_ok", bus.rx_src_ok, e[DW]);
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got time limit, expected test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit chk);
    @(negedge clk);
    a_rst = 1'b0;
    bus.pe_valid = 1'b1;
    bus.pe_dest = 4'd5;
    bus.pe_data = 32'h1234_5678;
    bus.sw_out_r = 1'b0;
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_sw_in_r", bus.sw_in_r, 0);
      check("rst_sw_out_w", bus.sw_out_w, 0);
      check("rst_sw_data_o", bus.sw_data_o, 0);
      check("rst_pe_ready", bus.pe_ready, 1);
      check("rst_rx_valid", bus.rx_valid, 0);
      check("rst_tx_cnt", bus.tx_cnt, 0);
      check("rst_rx_cnt", bus.rx_cnt, 0);
      check("rst_err_cnt", bus.err_cnt, 0);
    end
    a_rst = 1'b1;
    bus.pe_valid = 1'b0;
    tx_exp_q.delete();
    rx_exp_q.delete();
    tx_seen = 0;
    rx_model = 0;
    err_model = 0;
    rx_acked = 0;
  endtask

  task automatic push_word(input logic [AW-1:0] dest, input logic [DW-1:0] data);
    bit ok;
    @(negedge clk);
    bus.pe_valid = 1'b1;
    bus.pe_dest = dest;
    bus.pe_data = data;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.pe_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      tx_exp_q.push_back({1'b1, dest, data});
      @(posedge clk);
      #1;
    end else begin
      check("pe_accept_timeout", 0, 1);
    end
    bus.pe_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [BW-1:0] flit);
    logic [AW-1:0] dest;
    dest = flit[DW+AW-1:DW];
    @(negedge clk);
    bus.sw_out_r = 1'b1;
    bus.sw_data_i = flit;
    rx_exp_q.push_back({dest == AW'(MY), flit[DW-1:0]});
    rx_model++;
    if ((!flit[BW-1] || dest != AW'(MY)) && err_model < 255) err_model++;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.sw_out_w) break;
    end
    if (!bus.sw_out_w) check("rx_ack_timeout", 0, 1);
    rx_acked++;
    bus.sw_out_r = 1'b0;
    bus.sw_data_i = {$urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.sw_out_w) break;
    end
    if (bus.sw_out_w) check("rx_ack_release_timeout", 0, 1);
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 3000; i++) begin
      if (tx_exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("tx_drain", tx_exp_q.size(), 0);
  endtask

  task automatic wait_rx_drain();
    for (int i = 0; i < 3000; i++) begin
      if (rx_exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("rx_drain", rx_exp_q.size(), 0);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [DW-1:0] words [5];
    bus.pe_valid = 1'b0;
    bus.pe_dest = '0;
    bus.pe_data = '0;
    bus.sw_out_r = 1'b0;
    bus.sw_data_i = '0;

    // Reset with pe_valid held high, then nothing must have been enqueued
    do_reset(1'b1);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", bus.sw_in_r, 0);
    end
    check("post_rst_pe_ready", bus.pe_ready, 1);

    // Single TX, switch acks two cycles late
    sink_en = 1'b1;
    ack_delay = 2;
    push_word(4'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    check("single_flit_value", bus.sw_data_o, 64'h13_DEAD_BEEF);
    wait_tx_drain();
    check("single_tx_cnt", bus.tx_cnt, 1);

    // TX full: four words fill the FIFO while the switch never acks
    do_reset(1'b0);
    sink_en = 1'b0;
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    for (int i = 0; i < 4; i++) push_word(AW'(i + 1), words[i]);
    @(negedge clk);
    @(negedge clk);
    bus.pe_valid = 1'b1;
    bus.pe_dest = 4'd9;
    bus.pe_data = words[4];
    repeat (3) begin
      #1;
      check("tx_full_pe_ready", bus.pe_ready, 0);
      @(negedge clk);
    end
    bus.pe_valid = 1'b0;
    sink_en = 1'b1;
    ack_delay = 0;
    wait_tx_drain();
    check("tx_full_cnt", bus.tx_cnt, 4);

    // RX backpressure: the fifth flit waits until one PE pop
    do_reset(1'b0);
    rx_mode = 0;
    fork
      for (int i = 0; i < 5; i++) send_flit({1'b1, AW'(MY), 32'($urandom)});
      begin
        for (int i = 0; i < 300; i++) begin
          if (rx_acked >= 4) break;
          @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("rx_bp_acked", rx_acked, 4);
        check("rx_bp_w_low", bus.sw_out_w, 0);
        check("rx_bp_cnt4", bus.rx_cnt, 4);
        check("rx_bp_valid", bus.rx_valid, 1);
        pop_one = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (rx_acked >= 5) break;
        end
        check("rx_bp_acked5", rx_acked, 5);
      end
    join
    repeat (3) @(negedge clk);
    check("rx_bp_cnt5", bus.rx_cnt, 5);
    rx_mode = 1;
    wait_rx_drain();

    // Misrouted flits are stored, flagged and counted until saturation
    do_reset(1'b0);
    rx_mode = 0;
    send_flit({1'b1, 4'd7, 32'($urandom)});
    @(negedge clk);
    check("misroute_valid", bus.rx_valid, 1);
    check("misroute_src_ok", bus.rx_src_ok, 0);
    check("misroute_err1", bus.err_cnt, 1);
    rx_mode = 1;
    for (int i = 0; i < 299; i++) send_flit({1'b1, 4'd7, 32'($urandom)});
    wait_rx_drain();
    check("misroute_err_sat", bus.err_cnt, 255);
    check("misroute_rx_cnt", bus.rx_cnt, rx_model);

    // Random traffic on both paths at once
    do_reset(1'b0);
    sink_en = 1'b1;
    ack_delay = -1;
    rx_mode = 2;
    fork
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push_word(AW'($urandom_range(0, 15)), 32'($urandom));
      end
      for (int i = 0; i < 60; i++) begin
        send_flit({1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 32'($urandom)});
      end
    join
    wait_tx_drain();
    wait_rx_drain();
    check("rand_tx_cnt", bus.tx_cnt, 60);
    check("rand_tx_seen", tx_seen, 60);
    check("rand_rx_cnt", bus.rx_cnt, rx_model);
    check("rand_err_cnt", bus.err_cnt, err_model);

    // Reset while a flit is being offered
    do_reset(1'b0);
    sink_en = 1'b0;
    push_word(4'd3, 32'hCAFE_F00D);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sw_in_r) break;
    end
    check("mid_rst_req", bus.sw_in_r, 1);
    a_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_req_drop", bus.sw_in_r, 0);
    a_rst = 1'b1;
    tx_exp_q.delete();
    sink_en = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_idle", bus.sw_in_r, 0);
    check("mid_rst_pe_ready", bus.pe_ready, 1);
    check("mid_rst_tx_cnt", bus.tx_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
